// File: rtl/reg_port_sequencer.sv
// reg_port_sequencer
//
// Purpose: serialises one instruction-level register request (optional write,
// optional read rs, optional read rt) onto the single shared address port of
// the register file. The write goes first, then rs, then rt, and both read
// results come back together through a valid/ready response.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   req_valid/ready    request handshake; ready only while idle
//   wr_en/addr/data    optional write of the request
//   rs_en/addr         optional read A
//   rt_en/addr         optional read B
//   rsp_valid/ready    response handshake
//   rs_data, rt_data   read results (0 for disabled or invalid reads)
//   rsp_err            an enabled operation used an address >= DEPTH
//   rf_addr/data_in/we drive the register file port
//   rf_data_out        asynchronous read data from the register file
module reg_port_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rs_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic              rt_en,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_data_out
);

  typedef enum logic [2:0] {IDLE, WRITE, READ_A, READ_B, RESP} state_t;

  // One extra bit so that DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic              rs_en_q, rt_en_q;
  logic [ADDR_W-1:0] wr_addr_q, rs_addr_q, rt_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // Picks the first enabled phase in the fixed order WRITE, READ_A, READ_B;
  // callers pass 0 for phases already behind them.
  function automatic state_t first_phase(input logic w, input logic a, input logic b);
    if (w) return WRITE;
    if (a) return READ_A;
    if (b) return READ_B;
    return RESP;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rs_en_q   <= 1'b0;
      rt_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      wr_data_q <= '0;
      rs_data   <= '0;
      rt_data   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rs_en_q   <= rs_en;
            rt_en_q   <= rt_en;
            wr_addr_q <= wr_addr;
            rs_addr_q <= rs_addr;
            rt_addr_q <= rt_addr;
            wr_data_q <= wr_data;
            // Disabled reads must come back as 0, so clear on accept.
            rs_data   <= '0;
            rt_data   <= '0;
            rsp_err   <= 1'b0;
            state     <= first_phase(wr_en, rs_en, rt_en);
          end
        end
        WRITE: begin
          if (!addr_ok(wr_addr_q)) rsp_err <= 1'b1;
          state <= first_phase(1'b0, rs_en_q, rt_en_q);
        end
        READ_A: begin
          rs_data <= addr_ok(rs_addr_q) ? rf_data_out : '0;
          if (!addr_ok(rs_addr_q)) rsp_err <= 1'b1;
          state <= first_phase(1'b0, 1'b0, rt_en_q);
        end
        READ_B: begin
          rt_data <= addr_ok(rt_addr_q) ? rf_data_out : '0;
          if (!addr_ok(rt_addr_q)) rsp_err <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register-file port is only driven during its own phase. The write enable
  // is gated by reset so an interrupted WRITE never commits.
  always_comb begin
    rf_addr    = '0;
    rf_data_in = '0;
    rf_we      = 1'b0;
    case (state)
      WRITE: begin
        rf_addr    = wr_addr_q;
        rf_data_in = wr_data_q;
        rf_we      = addr_ok(wr_addr_q) && !reset;
      end
      READ_A:  rf_addr = rs_addr_q;
      READ_B:  rf_addr = rt_addr_q;
      default: ;
    endcase
  end

  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_reg_port_sequencer.sv
// tb_reg_port_sequencer
//
// Purpose: self-checking bench for reg_port_sequencer. Contains a simple
// register file model driven by the DUT and a behavioural reference model
// that predicts each response from the request alone.
module tb_reg_port_sequencer;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready;
  logic              wr_en, rs_en, rt_en;
  logic [ADDR_W-1:0] wr_addr, rs_addr, rt_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data_in, rf_data_out;
  logic              rf_we;

  int checks = 0;
  int errors = 0;

  reg_port_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_en(rs_en), .rs_addr(rs_addr), .rt_en(rt_en), .rt_addr(rt_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rs_data(rs_data), .rt_data(rt_data), .rsp_err(rsp_err),
    .rf_addr(rf_addr), .rf_data_in(rf_data_in), .rf_we(rf_we),
    .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, asynchronous read. Out-of-range reads
  // return a junk pattern so a missing zeroing in the DUT is visible.
  logic [DATA_W-1:0] init_vals [DEPTH];
  logic [DATA_W-1:0] rf_mem    [DEPTH];
  logic [DATA_W-1:0] ref_mem   [DEPTH];
  logic              load_mem;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) rf_mem[i] <= init_vals[i];
    end else if (rf_we) begin
      rf_mem[rf_addr[3:0]] <= rf_data_in;
    end
  end

  assign rf_data_out = (int'(rf_addr) < DEPTH) ? rf_mem[rf_addr[3:0]] : 32'hBAD0_BAD0;

  // Reference model results for the current request.
  int                exp_n, exp_we_cnt;
  logic [DATA_W-1:0] exp_rs, exp_rt;
  logic              exp_err;

  // Observations collected by the driver.
  int                obs_wait, obs_lat, obs_we_cnt;
  logic [ADDR_W-1:0] obs_we_addr;
  logic [DATA_W-1:0] obs_we_data;
  logic              obs_busy_ready;

  function automatic logic valid_addr(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  // Behavioural model: write first (if legal), then both reads see the
  // updated register contents; latency equals the number of enabled ops.
  task automatic model_request(input logic w, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd,
                               input logic a, input logic [ADDR_W-1:0] ra,
                               input logic b, input logic [ADDR_W-1:0] rb);
    exp_n      = int'(w) + int'(a) + int'(b);
    exp_err    = (w && !valid_addr(wa)) || (a && !valid_addr(ra)) || (b && !valid_addr(rb));
    exp_we_cnt = (w && valid_addr(wa)) ? 1 : 0;
    if (exp_we_cnt == 1) ref_mem[wa[3:0]] = wd;
    exp_rs = (a && valid_addr(ra)) ? ref_mem[ra[3:0]] : '0;
    exp_rt = (b && valid_addr(rb)) ? ref_mem[rb[3:0]] : '0;
  endtask

  // Drives one request (caller is at a falling edge), waits for acceptance
  // and then for rsp_valid, recording latency and any register-file writes.
  task automatic issue_request(input logic w, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd,
                               input logic a, input logic [ADDR_W-1:0] ra,
                               input logic b, input logic [ADDR_W-1:0] rb);
    req_valid = 1'b1;
    wr_en = w; wr_addr = wa; wr_data = wd;
    rs_en = a; rs_addr = ra; rt_en = b; rt_addr = rb;
    obs_wait = 0;
    while (!req_ready && obs_wait < 20) begin
      @(negedge clk);
      obs_wait++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    wr_en = 1'($urandom); wr_addr = ADDR_W'($urandom); wr_data = $urandom;
    rs_en = 1'($urandom); rs_addr = ADDR_W'($urandom);
    rt_en = 1'($urandom); rt_addr = ADDR_W'($urandom);
    obs_lat = 0; obs_we_cnt = 0; obs_busy_ready = 1'b0;
    obs_we_addr = '0; obs_we_data = '0;
    while (!rsp_valid && obs_lat < 10) begin
      if (rf_we) begin
        obs_we_cnt++;
        obs_we_addr = rf_addr;
        obs_we_data = rf_data_in;
      end
      if (req_ready) obs_busy_ready = 1'b1;
      @(negedge clk);
      obs_lat++;
    end
  endtask

  task automatic finish_response();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    wr_en = 1'b0; rs_en = 1'b0; rt_en = 1'b0;
    wr_addr = '0; rs_addr = '0; rt_addr = '0; wr_data = '0;
    load_mem = 1'b1;
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if ({rs_data, rt_data, rsp_err} !== '0) begin errors++; $display("[TB] FAIL reset_rsp_regs: got rs=%h rt=%h err=%b expected zeros", rs_data, rt_data, rsp_err); end
    checks++; if ({rf_addr, rf_data_in, rf_we} !== '0) begin errors++; $display("[TB] FAIL reset_rf_port: got addr=%h data=%h we=%b expected zeros", rf_addr, rf_data_in, rf_we); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_write_only();
    model_request(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_request(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    checks++; if (obs_lat != exp_n) begin errors++; $display("[TB] FAIL wo_latency: got %0d expected %0d", obs_lat, exp_n); end
    checks++; if (obs_we_cnt != exp_we_cnt) begin errors++; $display("[TB] FAIL wo_we_count: got %0d expected %0d", obs_we_cnt, exp_we_cnt); end
    checks++; if (obs_we_addr !== 5'd3 || obs_we_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wo_we_target: got %h/%h expected 03/deadbeef", obs_we_addr, obs_we_data); end
    checks++; if ({rs_data, rt_data, rsp_err} !== {exp_rs, exp_rt, exp_err}) begin errors++; $display("[TB] FAIL wo_response: got %h %h %b expected %h %h %b", rs_data, rt_data, rsp_err, exp_rs, exp_rt, exp_err); end
    checks++; if ({rf_addr, rf_data_in, rf_we} !== '0) begin errors++; $display("[TB] FAIL wo_rf_idle_in_resp: got %h %h %b expected zeros", rf_addr, rf_data_in, rf_we); end
    finish_response();
  endtask

  task automatic test_write_before_read();
    model_request(1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 1'b1, 5'd3);
    issue_request(1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 1'b1, 5'd3);
    checks++; if (obs_lat != exp_n) begin errors++; $display("[TB] FAIL wbr_latency: got %0d expected %0d", obs_lat, exp_n); end
    checks++; if (rs_data !== exp_rs) begin errors++; $display("[TB] FAIL wbr_rs_data: got %h expected %h", rs_data, exp_rs); end
    checks++; if (rt_data !== exp_rt) begin errors++; $display("[TB] FAIL wbr_rt_data: got %h expected %h", rt_data, exp_rt); end
    checks++; if (obs_busy_ready !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("[TB] FAIL wbr_busy_ready: got %b/%b expected 0/0", obs_busy_ready, req_ready); end
    finish_response();
  endtask

  task automatic test_no_phase();
    model_request(1'b0, 5'd1, 32'h5555_AAAA, 1'b0, 5'd2, 1'b0, 5'd3);
    issue_request(1'b0, 5'd1, 32'h5555_AAAA, 1'b0, 5'd2, 1'b0, 5'd3);
    checks++; if (obs_lat != exp_n) begin errors++; $display("[TB] FAIL np_latency: got %0d expected %0d", obs_lat, exp_n); end
    checks++; if (obs_we_cnt != 0) begin errors++; $display("[TB] FAIL np_we_count: got %0d expected 0", obs_we_cnt); end
    checks++; if ({rs_data, rt_data, rsp_err} !== {exp_rs, exp_rt, exp_err}) begin errors++; $display("[TB] FAIL np_response: got %h %h %b expected %h %h %b", rs_data, rt_data, rsp_err, exp_rs, exp_rt, exp_err); end
    finish_response();
  endtask

  task automatic test_invalid_addr();
    model_request(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b1, 5'd3);
    issue_request(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b1, 5'd3);
    checks++; if (obs_lat != exp_n) begin errors++; $display("[TB] FAIL inv_rd_latency: got %0d expected %0d", obs_lat, exp_n); end
    checks++; if ({rs_data, rt_data, rsp_err} !== {exp_rs, exp_rt, exp_err}) begin errors++; $display("[TB] FAIL inv_rd_response: got %h %h %b expected %h %h %b", rs_data, rt_data, rsp_err, exp_rs, exp_rt, exp_err); end
    finish_response();
    model_request(1'b1, 5'd17, 32'hCAFE_F00D, 1'b0, 5'd0, 1'b0, 5'd0);
    issue_request(1'b1, 5'd17, 32'hCAFE_F00D, 1'b0, 5'd0, 1'b0, 5'd0);
    checks++; if (obs_we_cnt != 0) begin errors++; $display("[TB] FAIL inv_wr_we_count: got %0d expected 0", obs_we_cnt); end
    checks++; if (obs_lat != exp_n || rsp_err !== exp_err) begin errors++; $display("[TB] FAIL inv_wr_response: got lat=%0d err=%b expected lat=%0d err=%b", obs_lat, rsp_err, exp_n, exp_err); end
    finish_response();
    model_request(1'b0, 5'd31, 32'h1, 1'b0, 5'd25, 1'b1, 5'd3);
    issue_request(1'b0, 5'd31, 32'h1, 1'b0, 5'd25, 1'b1, 5'd3);
    checks++; if ({rs_data, rt_data, rsp_err} !== {exp_rs, exp_rt, exp_err}) begin errors++; $display("[TB] FAIL inv_disabled_ignored: got %h %h %b expected %h %h %b", rs_data, rt_data, rsp_err, exp_rs, exp_rt, exp_err); end
    finish_response();
  endtask

  task automatic test_hold_and_back_to_back();
    model_request(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd20);
    issue_request(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd20);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          {rs_data, rt_data, rsp_err} !== {exp_rs, exp_rt, exp_err}) begin
        errors++;
        $display("[TB] FAIL hold_stable[%0d]: got v=%b r=%b %h %h %b expected v=1 r=0 %h %h %b",
                 i, rsp_valid, req_ready, rs_data, rt_data, rsp_err, exp_rs, exp_rt, exp_err);
      end
      @(negedge clk);
    end
    finish_response();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle_after_rsp: got v=%b r=%b expected v=0 r=1", rsp_valid, req_ready); end
    model_request(1'b1, 5'd9, 32'h0BAD_F00D, 1'b1, 5'd9, 1'b0, 5'd0);
    issue_request(1'b1, 5'd9, 32'h0BAD_F00D, 1'b1, 5'd9, 1'b0, 5'd0);
    checks++; if (obs_wait != 0) begin errors++; $display("[TB] FAIL b2b_accept_wait: got %0d expected 0", obs_wait); end
    checks++; if (obs_lat != exp_n || rs_data !== exp_rs) begin errors++; $display("[TB] FAIL b2b_response: got lat=%0d rs=%h expected lat=%0d rs=%h", obs_lat, rs_data, exp_n, exp_rs); end
    finish_response();
  endtask

  task automatic test_reset_mid_write();
    int guard;
    req_valid = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
    rs_en = 1'b0; rt_en = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0; wr_en = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd7) begin errors++; $display("[TB] FAIL rst_mid_in_write: got we=%b addr=%h expected we=1 addr=07", rf_we, rf_addr); end
    reset = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_we_gated: got %b expected 0", rf_we); end
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rs_data, rt_data, rsp_err, rf_addr, rf_data_in, rf_we} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: got r=%b v=%b %h %h %b %h %h %b expected zeros",
               req_ready, rsp_valid, rs_data, rt_data, rsp_err, rf_addr, rf_data_in, rf_we);
    end
    reset = 1'b0;
    @(negedge clk);
    model_request(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
    issue_request(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
    checks++; if (rs_data !== exp_rs) begin errors++; $display("[TB] FAIL rst_mid_r7_kept: got %h expected %h", rs_data, exp_rs); end
    finish_response();
  endtask

  task automatic test_random();
    logic              w, a, b;
    logic [ADDR_W-1:0] wa, ra, rb;
    logic [DATA_W-1:0] wd;
    int                hold;
    for (int n = 0; n < 40; n++) begin
      w  = 1'($urandom); a = 1'($urandom); b = 1'($urandom);
      wa = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(16, 31)) : ADDR_W'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(16, 31)) : ADDR_W'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(16, 31)) : ADDR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) ra = wa;
      wd = $urandom;
      hold = $urandom_range(0, 2);
      model_request(w, wa, wd, a, ra, b, rb);
      issue_request(w, wa, wd, a, ra, b, rb);
      checks++; if (obs_lat != exp_n || obs_we_cnt != exp_we_cnt) begin errors++; $display("[TB] FAIL rnd_timing[%0d]: got lat=%0d we=%0d expected lat=%0d we=%0d", n, obs_lat, obs_we_cnt, exp_n, exp_we_cnt); end
      if (exp_we_cnt == 1) begin
        checks++; if (obs_we_addr !== wa || obs_we_data !== wd) begin errors++; $display("[TB] FAIL rnd_write[%0d]: got %h/%h expected %h/%h", n, obs_we_addr, obs_we_data, wa, wd); end
      end
      repeat (hold) @(negedge clk);
      checks++; if ({rs_data, rt_data, rsp_err} !== {exp_rs, exp_rt, exp_err}) begin errors++; $display("[TB] FAIL rnd_response[%0d]: got %h %h %b expected %h %h %b", n, rs_data, rt_data, rsp_err, exp_rs, exp_rt, exp_err); end
      finish_response();
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_return_idle[%0d]: got r=%b v=%b expected r=1 v=0", n, req_ready, rsp_valid); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      init_vals[i] = $urandom;
      ref_mem[i]   = init_vals[i];
    end
    test_reset();
    test_write_only();
    test_write_before_read();
    test_no_phase();
    test_invalid_addr();
    test_hold_and_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached with %0d checks done", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/reg_port_sequencer.md
# reg_port_sequencer

Sequences the single-port 32-bit register file so that a core can issue one instruction-level register request per transaction: up to one write and two reads (rs, rt). The register file has one shared address port. This block serialises the operations onto it: the write goes first, then read rs, then read rt. It returns both read values together through a valid/ready response handshake. It sits between the decode/writeback stages and the register file and is the only driver of the register file's address, data and write-enable.

## Interface
Parameters:
- ADDR_W, 5, register address width (matches register file Addr)
- DATA_W, 32, data width
- DEPTH, 16, number of implemented registers; addresses >= DEPTH are invalid

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- wr_en  in  1  request includes a write
- wr_addr  in  ADDR_W  write register index
- wr_data  in  DATA_W  write value
- rs_en  in  1  request includes read A
- rs_addr  in  ADDR_W  read A register index
- rt_en  in  1  request includes read B
- rt_addr  in  ADDR_W  read B register index
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rs_data  out  DATA_W  read A result
- rt_data  out  DATA_W  read B result
- rsp_err  out  1  at least one enabled operation used an invalid address
- rf_addr  out  ADDR_W  to register file Addr
- rf_data_in  out  DATA_W  to register file DataIn
- rf_we  out  1  to register file regWE
- rf_data_out  in  DATA_W  from register file DataOut (asynchronous read)

## Operation
- FSM states: IDLE, WRITE, READ_A, READ_B, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid the block latches all request fields, clears rs_data, rt_data and rsp_err to 0, then goes to the first enabled phase in the order WRITE, READ_A, READ_B.
  - If no phase is enabled it goes directly to RESP.
- **WRITE**
  - rf_addr=wr_addr, rf_data_in=wr_data, rf_we=1.
  - Next state is the next enabled phase.
- **READ_A**
  - rf_addr=rs_addr.
  - rs_data captures rf_data_out on the exiting edge.
- **READ_B**
  - Same as READ_A, using rt_addr and rt_data.
- **RESP**
  - rsp_valid=1; rs_data, rt_data and rsp_err are held stable.
  - Returns to IDLE on the edge where rsp_ready=1.
- **Write-before-read:** a read of the register written in the same request returns the new value, because the write commits at the end of the WRITE cycle.
- **Invalid address** (address >= DEPTH, i.e. bit 4 set for the defaults):
  - The phase still consumes its cycle.
  - A write is suppressed (rf_we=0); a read captures 0.
  - rsp_err is set.
  - Addresses of disabled operations are ignored.
- **Disabled reads** return 0.
- **rf outputs:** rf_addr, rf_data_in and rf_we are 0 outside their active phase.
- **Reset value of every output:** req_ready=0 while reset is high, then 1 from the first cycle in IDLE. rsp_valid=0, rs_data=0, rt_data=0, rsp_err=0, rf_addr=0, rf_data_in=0, rf_we=0.

## Timing
- The accept edge is the rising edge with req_valid & req_ready.
- N = number of enabled phases (0..3).
- rsp_valid goes high in the cycle after edge N counted from the accept edge (accept edge = edge 0). Examples: N=3 gives rsp_valid after the 3rd edge following accept; N=0 gives rsp_valid in the cycle right after accept.
- rsp_valid is held until the rsp_ready edge.
- Back-to-back throughput:
  - The next request can be accepted no earlier than the cycle after the rsp_ready edge (IDLE has req_ready=1).
  - Minimum period is N+2 cycles.
- req_ready is 0 in every non-IDLE state. Request inputs are don't-care after the accept edge.
- Reset mid-operation:
  - The next state is IDLE and any response is discarded.
  - rf_we is gated by !reset, so a WRITE in progress when reset is high does not commit.
- rs_data and rt_data change only on capture edges or the accept edge.

## Test plan
- Reset, then write r3=0xDEADBEEF with reads disabled -> rf_we high exactly 1 cycle with rf_addr=3; rsp_valid one edge later; rs_data=rt_data=0, rsp_err=0.
- Request wr r5=0x12345678, rs=5, rt=3 -> rsp_valid 3 edges after accept; rs_data=0x12345678 (write-before-read), rt_data=0xDEADBEEF.
- Request with no phases enabled -> rsp_valid in the cycle after accept; rf_we never asserted.
- rs_addr=20 with rt=3 and no write -> rs_data=0, rt_data=0xDEADBEEF, rsp_err=1. Then wr_addr=17 -> rf_we stays 0 and rsp_err=1.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, data and rsp_err stable and req_ready=0 throughout. Raise rsp_ready, then issue a second request -> it is accepted the cycle after.
- Assert reset during WRITE of r7=0x1 -> no rf_we at that edge, all outputs reach reset values. A later read of r7 returns its prior contents.
